core_run_ctrl: RTL and testbench
================================

# core_run_ctrl

Parametrised run controller placed between the bench clock/reset and the core top (single-cycle or successors). It holds core reset for a programmable number of cycles after a start request, then lets the core run while it counts cycles and retired instructions. The run ends on a halt-PC match (done), a cycle budget (timeout) or a retire stall (stalled). It replaces hand-timed reset/finish delays with a deterministic, checkable run sequence.

## Interface
- RST_CYCLES, 3, cycles core_rst is held high after start (≥1)
- MAX_CYCLES, 1000, RUN-cycle budget before timeout (≥2)
- STALL_LIMIT, 16, consecutive RUN cycles without retire that trigger stalled (≥1)
- PC_W, 32, program counter width
- CNT_W, 32, counter width; must hold MAX_CYCLES

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, single-cycle pulse
- halt_pc  in  PC_W  PC whose retirement ends the run
- pc  in  PC_W  PC of the instruction retiring this cycle
- retire  in  1  instruction retired this cycle
- core_rst  out  1  reset to core; reset value 1
- running  out  1  high in RUN; reset value 0
- done  out  1  halt reached; reset value 0
- timeout  out  1  budget exhausted; reset value 0
- stalled  out  1  retire stall detected; reset value 0
- cycle_cnt  out  CNT_W  RUN cycles completed; reset value 0
- retire_cnt  out  CNT_W  instructions retired in RUN; reset value 0

## Operation
- States: IDLE, RESET, RUN, DONE, TIMEOUT, STALL. All outputs are registered.
- IDLE: core_rst=1. start → RESET, counters cleared.
- RESET: core_rst=1. The phase counter runs RST_CYCLES cycles, then → RUN, core_rst=0.
- RUN: each cycle cycle_cnt+1.
  - retire → retire_cnt+1 and the stall counter clears.
  - No retire → stall counter+1.
- Exit conditions from RUN, evaluated on the same edge. Priority: halt > timeout > stall.
  - Halt: retire && pc==halt_pc → DONE.
  - Timeout: cycle_cnt==MAX_CYCLES-1 → TIMEOUT.
  - Stall: stall counter==STALL_LIMIT-1 and no retire → STALL.
- The exiting cycle is counted. Its retire is also counted when present.
- DONE/TIMEOUT/STALL: core_rst=1, the core is frozen, counters hold, and the matching flag is 1.
- start in a terminal state → RESET. Flags and counters clear on that edge.
- start is ignored in RESET and RUN.
- rst asserted at any time, including mid-RUN: immediately IDLE, all outputs go to their reset values, and in-flight counts are discarded.
- Counters cannot overflow: cycle_cnt ≤ MAX_CYCLES and retire_cnt ≤ cycle_cnt.

## Timing
- start sampled high at edge k:
  - core_rst stays 1 for edges k..k+RST_CYCLES-1.
  - core_rst falls and running rises at edge k+RST_CYCLES.
- First RUN cycle is cycle k+RST_CYCLES. cycle_cnt=1 after its closing edge.
- Halt observed in RUN cycle n (1-based): at the closing edge done=1, running=0, core_rst=1 and cycle_cnt=n.
- Timeout with no halt: timeout=1 and cycle_cnt=MAX_CYCLES.
- Halt and timeout on the same cycle: done=1, timeout=0.
- Exactly one of done/timeout/stalled is high at a time.

## Structure
- Shared package core_run_pkg holds:
  - the run_state_t enum (IDLE, RESET, RUN, DONE, TIMEOUT, STALL);
  - default constants for RST_CYCLES, MAX_CYCLES and STALL_LIMIT.
- One sub-module, core_run_cnt: CNT_W counter with synchronous clear and enable and asynchronous rst. It is instantiated for the phase, cycle, retire and stall counters.
- The FSM stays in core_run_ctrl.

## Test plan
- Reset: rst=1 for 3 cycles then 0, no start → core_rst=1, all flags 0, counters 0, state IDLE indefinitely.
- Normal halt (RST_CYCLES=3): start at edge 5, retire every cycle with pc=0,4,8,…, halt_pc=0x20.
  - core_rst falls at edge 8.
  - done=1 after 9 RUN cycles; cycle_cnt=9, retire_cnt=9.
- Timeout (MAX_CYCLES=20): halt_pc never matches, retire every cycle → timeout=1 with cycle_cnt=20, retire_cnt=20.
- Stall (STALL_LIMIT=4): retire 2 cycles then never → stalled=1 with cycle_cnt=6, retire_cnt=2.
- Priority: halt match on cycle MAX_CYCLES → done=1, timeout=0.
- Restart and mid-run reset:
  - start again in DONE → counters 0, RESET for RST_CYCLES, second run completes identically.
  - rst pulsed mid-RUN → immediately IDLE, core_rst=1, counters 0.

Source files
------------

// File: rtl/core_run_pkg.sv
// ============================================================================
// core_run_pkg : shared run-controller state encoding and default parameters
// Rev 1.0
// ============================================================================
`default_nettype none

package core_run_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4,
    STALL   = 3'd5
  } run_state_t;

  localparam int DEF_RST_CYCLES  = 3;
  localparam int DEF_MAX_CYCLES  = 1000;
  localparam int DEF_STALL_LIMIT = 16;

endpackage

`default_nettype wire

// File: rtl/core_run_cnt.sv
// ============================================================================
// core_run_cnt : up-counter with synchronous clear (priority) and enable
// Rev 1.0
// ============================================================================
`default_nettype none

module core_run_cnt
  import core_run_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= q + CNT_W'(1);
  end

endmodule

`default_nettype wire

// File: rtl/core_run_ctrl.sv
// ============================================================================
// core_run_ctrl : holds core reset after start, runs the core, and ends the
//                 run on halt-PC retire, cycle budget or retire stall
// Rev 1.0
// ============================================================================
`default_nettype none

module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  halt_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic             retire,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             stalled,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

  run_state_t       state, next_state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             in_run;
  logic             terminal;
  logic             start_ok;
  logic             halt_hit;
  logic             budget_hit;
  logic             stall_hit;

  assign in_run     = (state == RUN);
  assign terminal   = (state == DONE) || (state == TIMEOUT) || (state == STALL);
  assign start_ok   = start && ((state == IDLE) || terminal);
  assign halt_hit   = retire && (pc == halt_pc);
  assign budget_hit = (cycle_cnt == CYCLE_LAST);
  assign stall_hit  = !retire && (stall_cnt == STALL_LAST);

  core_run_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (state == RESET),
    .q   (phase_cnt)
  );

  core_run_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (in_run),
    .q   (cycle_cnt)
  );

  core_run_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (in_run && retire),
    .q   (retire_cnt)
  );

  // Any retire restarts the idle-cycle count, so it measures consecutive gaps.
  core_run_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok || (in_run && retire)),
    .en  (in_run && !retire),
    .q   (stall_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RESET;
      RESET:   if (phase_cnt == PHASE_LAST) next_state = RUN;
      RUN: begin
        if (halt_hit)        next_state = DONE;
        else if (budget_hit) next_state = TIMEOUT;
        else if (stall_hit)  next_state = STALL;
      end
      DONE, TIMEOUT, STALL: if (start) next_state = RESET;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode the state register only, so they change solely on edges.
  always_comb begin
    core_rst = 1'b1;
    running  = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    stalled  = 1'b0;
    case (state)
      RUN: begin
        core_rst = 1'b0;
        running  = 1'b1;
      end
      DONE:    done    = 1'b1;
      TIMEOUT: timeout = 1'b1;
      STALL:   stalled = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
// ============================================================================
// tb_core_run_ctrl : scoreboard bench for core_run_ctrl with a per-run model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_run_ctrl;

  localparam int RST_CYCLES  = 3;
  localparam int MAX_CYCLES  = 20;
  localparam int STALL_LIMIT = 4;
  localparam int PC_W        = 32;
  localparam int CNT_W       = 32;
  localparam int DEPTH       = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PC_W-1:0]  halt_pc = '0;
  logic [PC_W-1:0]  pc = '0;
  logic             retire = 1'b0;
  logic             core_rst, running, done, timeout, stalled;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  core_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .STALL_LIMIT(STALL_LIMIT),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_pc   (halt_pc),
    .pc        (pc),
    .retire    (retire),
    .core_rst  (core_rst),
    .running   (running),
    .done      (done),
    .timeout   (timeout),
    .stalled   (stalled),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = done, 1 = timeout, 2 = stalled
  typedef struct {
    int kind;
    int cycles;
    int retires;
  } exp_t;

  exp_t            sb_q[$];
  bit              cur_ret[DEPTH];
  logic [PC_W-1:0] cur_pc[DEPTH];
  int              total  = 0;
  int              passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp)
      passed++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk the run's instruction stream cycle by cycle and apply the
  // end-of-run rules in priority order.
  function automatic exp_t model(input logic [PC_W-1:0] hpc);
    exp_t e;
    int   idle_run;
    e.kind    = 1;
    e.cycles  = MAX_CYCLES;
    e.retires = 0;
    idle_run  = 0;
    for (int n = 1; n <= MAX_CYCLES; n++) begin
      if (cur_ret[n-1]) begin
        e.retires++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (cur_ret[n-1] && cur_pc[n-1] == hpc) begin
        e.kind = 0; e.cycles = n; return e;
      end
      if (n == MAX_CYCLES) begin
        e.kind = 1; e.cycles = n; return e;
      end
      if (idle_run == STALL_LIMIT) begin
        e.kind = 2; e.cycles = n; return e;
      end
    end
    return e;
  endfunction

  // Stream driver: feeds instruction n during RUN cycle n, random noise otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (running && cycle_cnt < CNT_W'(DEPTH)) begin
        retire = cur_ret[cycle_cnt[5:0]];
        pc     = cur_pc[cycle_cnt[5:0]];
      end else begin
        retire = 1'($urandom_range(0, 1));
        pc     = $urandom;
      end
    end
  end

  // Monitor: each new end-of-run indication is matched against the scoreboard.
  initial begin
    bit   prev_end;
    bit   now_end;
    exp_t e;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      now_end = done | timeout | stalled;
      if (now_end && !prev_end) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_end", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("end_flags", {stalled, timeout, done}, 3'b001 << e.kind);
          check("end_cycle_cnt", cycle_cnt, e.cycles);
          check("end_retire_cnt", retire_cnt, e.retires);
          check("end_running", running, 0);
          check("end_core_rst", core_rst, 1);
        end
      end
      prev_end = now_end;
    end
  end

  task automatic run_scenario(input logic [PC_W-1:0] hpc);
    int n;
    halt_pc = hpc;
    sb_q.push_back(model(hpc));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_cleared_flags", {done, timeout, stalled, running}, 0);
    check("start_cleared_cycles", cycle_cnt, 0);
    check("start_cleared_retires", retire_cnt, 0);
    n = 0;
    while (core_rst && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("core_rst_len", n, RST_CYCLES);
    check("running_after_reset", running, 1);
    n = 0;
    while (!(done | timeout | stalled) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("run_end_bound", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_linear(input bit all_retire);
    for (int i = 0; i < DEPTH; i++) begin
      cur_ret[i] = all_retire;
      cur_pc[i]  = PC_W'(4 * i);
    end
  endtask

  initial begin
    int n;
    // Reset behaviour
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {core_rst, running, done, timeout, stalled}, 5'b10000);
    check("reset_counts", {cycle_cnt, retire_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("idle_outputs", {core_rst, running, done, timeout, stalled}, 5'b10000);
    check("idle_counts", {cycle_cnt, retire_cnt}, 0);

    // Normal halt at pc 0x20, then restart from DONE with the same program
    fill_linear(1'b1);
    run_scenario(32'h20);
    run_scenario(32'h20);

    // Timeout: halt never matches
    run_scenario(32'hFFFF_FFFC);

    // Stall: two retires then none
    fill_linear(1'b0);
    cur_ret[0] = 1'b1;
    cur_ret[1] = 1'b1;
    run_scenario(32'h1000);

    // Halt on the final budget cycle wins over timeout
    fill_linear(1'b1);
    run_scenario(PC_W'(4 * (MAX_CYCLES - 1)));

    // Randomized programs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cur_ret[i] = ($urandom_range(0, 3) != 0);
        cur_pc[i]  = PC_W'($urandom_range(0, 15) * 4);
      end
      run_scenario(PC_W'($urandom_range(0, 15) * 4));
    end

    // Asynchronous reset mid-RUN
    fill_linear(1'b1);
    halt_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!running && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrun_reached_run", running, 1);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", {core_rst, running, done, timeout, stalled}, 5'b10000);
    check("midrun_rst_counts", {cycle_cnt, retire_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", {core_rst, running, cycle_cnt}, {1'b1, 1'b0, 32'd0});

    // Controller still runs normally after the abort
    run_scenario(32'h20);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
